// File: rtl/writeback_reg_r_pkg.sv
// Shared encodings for the writeback stage: instruction classes, register
// numbers with special meaning, and the load-wait state machine states.
package writeback_reg_r_pkg;

  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LDST   = 3'b010;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  // TST/TEQ/CMP/CMN only set flags and never write a register
  localparam logic [3:0] CMP_OP_LO = 4'b1000;
  localparam logic [3:0] CMP_OP_HI = 4'b1011;

  localparam logic [3:0] PC_REG = 4'd15;
  localparam logic [3:0] LR_REG = 4'd14;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_reg_r_classify.sv
// Combinational decode of a retiring ARM instruction into its writeback class.
module wb_classify
  import writeback_reg_r_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_load,
  output logic        writes_rd,
  output logic        is_bl
);

  logic [2:0] cls_s;
  logic [3:0] op_s;
  logic       unused_s;

  assign cls_s    = inst[27:25];
  assign op_s     = inst[24:21];
  assign unused_s = ^{inst[31:28], inst[19:0]};

  // Class decode; every class not listed retires without a register write
  always_comb begin
    is_load   = 1'b0;
    writes_rd = 1'b0;
    is_bl     = 1'b0;
    case (cls_s)
      CLS_DP_REG, CLS_DP_IMM: begin
        if ((op_s >= CMP_OP_LO) && (op_s <= CMP_OP_HI)) begin
          writes_rd = 1'b0;
        end else begin
          writes_rd = 1'b1;
        end
      end
      CLS_LDST:   is_load = inst[20];
      CLS_BRANCH: is_bl   = inst[24];
      default: begin
        is_load   = 1'b0;
        writes_rd = 1'b0;
        is_bl     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/writeback_reg_r.sv
// Writeback stage: retires instructions, waits for load data, and turns any
// write to r15 into a PC redirect with a pipeline flush.
module writeback_reg_r
  import writeback_reg_r_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_result_i,
  input  logic [3:0]  rd_addr_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic [31:0] wb_data_o,
  output logic [3:0]  wb_addr_o,
  output logic        wb_en_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e        state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [3:0]       ld_rd_r, ld_rd_nx_s;
  logic             err_nx_s;
  logic             accept_s, retire_s, write_s, redirect_s, wen_s;
  logic [3:0]       addr_s;
  logic [31:0]      data_s;
  logic             is_load_s, writes_rd_s, is_bl_s;

  wb_classify u_classify (
    .inst      (inst_i),
    .is_load   (is_load_s),
    .writes_rd (writes_rd_s),
    .is_bl     (is_bl_s)
  );

  assign accept_s = valid_i & ~flush_i & ~stall_i & (state_r == IDLE);
  assign stall_o  = (state_r == LOAD_WAIT);

  // Next-state, counter and retirement decision for this cycle
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    ld_rd_nx_s = ld_rd_r;
    err_nx_s   = err_o;
    retire_s   = 1'b0;
    write_s    = 1'b0;
    addr_s     = wb_addr_o;
    data_s     = wb_data_o;
    case (state_r)
      IDLE: begin
        if (accept_s && is_load_s) begin
          state_nx_s = LOAD_WAIT;
          cnt_nx_s   = {CNT_W{1'b0}};
          ld_rd_nx_s = rd_addr_i;
        end else if (accept_s) begin
          retire_s = 1'b1;
          if (is_bl_s) begin
            write_s = 1'b1;
            addr_s  = LR_REG;
            data_s  = pc_i + 32'd4;
          end else if (writes_rd_s) begin
            write_s = 1'b1;
            addr_s  = rd_addr_i;
            data_s  = alu_result_i;
          end else begin
            write_s = 1'b0;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD_WAIT: begin
        cnt_nx_s = cnt_r + CNT_W'(1);
        // A response on the final wait cycle still completes the load
        if (mem_rvalid_i) begin
          state_nx_s = IDLE;
          retire_s   = 1'b1;
          write_s    = 1'b1;
          addr_s     = ld_rd_r;
          data_s     = mem_rdata_i;
        end else if (cnt_r == CNT_LAST) begin
          state_nx_s = IDLE;
          err_nx_s   = 1'b1;
        end else begin
          state_nx_s = LOAD_WAIT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  assign redirect_s = write_s & (addr_s == PC_REG);
  assign wen_s      = write_s & ~redirect_s;

  // State, counter and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      ld_rd_r       <= 4'd0;
      err_o         <= 1'b0;
      valid_o       <= 1'b0;
      wb_en_o       <= 1'b0;
      wb_addr_o     <= 4'd0;
      wb_data_o     <= 32'd0;
      flush_o       <= 1'b0;
      pc_redirect_o <= 1'b0;
      pc_target_o   <= 32'd0;
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      ld_rd_r       <= ld_rd_nx_s;
      err_o         <= err_nx_s;
      valid_o       <= retire_s;
      wb_en_o       <= wen_s;
      wb_addr_o     <= addr_s;
      wb_data_o     <= data_s;
      flush_o       <= redirect_s;
      pc_redirect_o <= redirect_s;
      pc_target_o   <= redirect_s ? data_s : pc_target_o;
    end
  end

endmodule
